// File: rtl/bpfcap_pkg.sv
// Shared types and widths for the packet-capture datapath (reader, FIFO, write-side controller).
package bpfcap_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DATA,
    RD_DONE
  } rd_state_t;

  localparam int BPFCAP_DATA_W    = 32;
  localparam int BPFCAP_MAX_BURST = 8;

endpackage

// File: rtl/pkt_mem_reader.sv
// Avalon-MM burst-read master: copies one packet (base address, length in words) from
// packet memory into the capture FIFO, one burst in flight, honouring FIFO back-pressure.
module pkt_mem_reader
  import bpfcap_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = BPFCAP_DATA_W,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = BPFCAP_MAX_BURST,
  localparam int BURST_W  = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [BURST_W-1:0] avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_almost_full
);

  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

  rd_state_t          state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [BURST_W-1:0] outstanding_q;
  logic               pend_q;       // read presented and stalled: must stay up until accepted
  logic [BURST_W-1:0] burst_len;
  logic               in_issue;
  logic               accepted;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned,
  // otherwise synthesis infers a latch.
  always_comb begin
    burst_len = BURST_W'(MAX_BURST);
    if (remaining_q < LEN_W'(MAX_BURST)) begin
      burst_len = BURST_W'(remaining_q);
    end
  end

  // Back-pressure only gates a new request; a stalled request is held per Avalon rules.
  assign in_issue       = (state_q == RD_ISSUE);
  assign avm_read       = in_issue && (!fifo_almost_full || pend_q);
  assign avm_address    = in_issue ? addr_q : '0;
  assign avm_burstcount = in_issue ? burst_len : '0;
  assign accepted       = avm_read && !avm_waitrequest;

  assign busy = (state_q == RD_ISSUE) || (state_q == RD_DATA);
  assign done = (state_q == RD_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RD_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      pend_q        <= 1'b0;
      fifo_wrreq    <= 1'b0;
      fifo_data     <= '0;
    end else begin
      fifo_wrreq <= 1'b0;
      unique case (state_q)
        RD_IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= len_words;
            state_q     <= (len_words == '0) ? RD_DONE : RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (accepted) begin
            remaining_q   <= remaining_q - LEN_W'(burst_len);
            addr_q        <= addr_q + (ADDR_W'(burst_len) << BYTE_SHIFT);
            outstanding_q <= burst_len;
            pend_q        <= 1'b0;
            state_q       <= RD_DATA;
          end else if (avm_read) begin
            pend_q <= 1'b1;
          end
        end
        RD_DATA: begin
          // Beats arriving in any other state are stale and deliberately dropped.
          if (avm_readdatavalid) begin
            fifo_wrreq    <= 1'b1;
            fifo_data     <= avm_readdata;
            outstanding_q <= outstanding_q - BURST_W'(1);
            if (outstanding_q == BURST_W'(1)) begin
              state_q <= (remaining_q == '0) ? RD_DONE : RD_ISSUE;
            end
          end
        end
        RD_DONE: begin
          state_q <= RD_IDLE;
        end
        default: begin
          state_q <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_mem_reader.sv
// Directed bench for pkt_mem_reader: Avalon burst slave model, FIFO monitor, scenario tasks.
module tb_pkt_mem_reader;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 16;
  localparam int MAX_BURST = 8;
  localparam int BURST_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [LEN_W-1:0]   len_words;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  avm_address;
  logic               avm_read;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_waitrequest;
  logic [DATA_W-1:0]  avm_readdata;
  logic               avm_readdatavalid;
  logic               fifo_wrreq;
  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_almost_full;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pkt_mem_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len_words(len_words),
    .busy(busy), .done(done), .avm_address(avm_address), .avm_read(avm_read),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_almost_full(fifo_almost_full)
  );

  // Packet memory contents as a pure function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- Avalon slave model ----------------
  logic [31:0] beat_q[$];
  logic [31:0] burst_addr_q[$];
  int          burst_cnt_q[$];
  int          stall_idx = -1;
  int          stall_len = 0;
  int          cur_stall = 0;
  int          stall_total = 0;
  int          stab_bad = 0;
  logic [31:0] hold_addr = '0;
  logic [3:0]  hold_cnt = '0;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      #1;
      if (beat_q.size() > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = beat_q.pop_front();
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
      end
      avm_waitrequest = 1'b0;
      if (avm_read) begin
        if (burst_addr_q.size() == stall_idx && cur_stall < stall_len) begin
          if (cur_stall == 0) begin
            hold_addr = avm_address;
            hold_cnt  = avm_burstcount;
          end else if (avm_address !== hold_addr || avm_burstcount !== hold_cnt) begin
            stab_bad++;
          end
          avm_waitrequest = 1'b1;
          cur_stall++;
          stall_total++;
        end else begin
          if (cur_stall > 0 && (avm_address !== hold_addr || avm_burstcount !== hold_cnt))
            stab_bad++;
          burst_addr_q.push_back(avm_address);
          burst_cnt_q.push_back(int'(avm_burstcount));
          for (int i = 0; i < int'(avm_burstcount); i++)
            beat_q.push_back(mem_word(avm_address + 32'(4 * i)));
          cur_stall = 0;
        end
      end else if (cur_stall > 0) begin
        stab_bad++;
      end
    end
  end

  // ---------------- FIFO / status monitor ----------------
  logic [31:0] wr_q[$];
  int done_cnt = 0;
  int busy_cyc = 0;
  int read_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (fifo_wrreq) wr_q.push_back(fifo_data);
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (avm_read) read_cyc++;
    end
  end

  // Number of FIFO words, starting at index w0, that differ from the packet at base.
  function automatic int stream_errors(input int w0, input logic [31:0] base, input int len);
    int e = 0;
    for (int i = 0; i < len; i++) begin
      if (w0 + i >= wr_q.size()) e++;
      else if (wr_q[w0 + i] !== mem_word(base + 32'(4 * i))) e++;
    end
    return e;
  endfunction

  task automatic start_copy(input logic [31:0] base, input logic [15:0] len);
    @(negedge clk);
    start = 1'b1; base_addr = base; len_words = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #3;
      if (done_cnt > d0) ok = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    n_cmp++;
    if ({avm_read, busy, done, fifo_wrreq} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctl: read/busy/done/wrreq got %b expected 0000",
               {avm_read, busy, done, fifo_wrreq});
    end
    n_cmp++;
    if (avm_address !== '0 || avm_burstcount !== '0 || fifo_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr %h bc %0d fifo_data %h expected all 0",
               avm_address, avm_burstcount, fifo_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_copy();
    int w0 = wr_q.size();
    int d0 = done_cnt;
    int b0 = burst_addr_q.size();
    logic [31:0] ea[3] = '{32'h1000, 32'h1020, 32'h1040};
    int ec[3] = '{8, 8, 4};
    bit ok;
    start_copy(32'h1000, 16'd20);
    wait_done(d0, 200, ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_done: no done within 200 cycles"); end
    n_cmp++;
    if (wr_q.size() - w0 != 20) begin
      n_err++; $display("FAIL basic_count: got %0d words expected 20", wr_q.size() - w0);
    end
    n_cmp++;
    if (stream_errors(w0, 32'h1000, 20) != 0) begin
      n_err++; $display("FAIL basic_data: %0d wrong words expected 0", stream_errors(w0, 32'h1000, 20));
    end
    n_cmp++;
    if (burst_addr_q.size() - b0 != 3) begin
      n_err++; $display("FAIL basic_nbursts: got %0d expected 3", burst_addr_q.size() - b0);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (burst_addr_q[b0 + i] !== ea[i] || burst_cnt_q[b0 + i] != ec[i]) begin
        n_err++;
        $display("FAIL basic_burst%0d: got %h/%0d expected %h/%0d", i,
                 burst_addr_q[b0 + i], burst_cnt_q[b0 + i], ea[i], ec[i]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_done_once: done %0d busy %b expected 1 and 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_zero_length();
    int d0 = done_cnt;
    int b0 = burst_addr_q.size();
    int r0 = read_cyc;
    int bu0 = busy_cyc;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h1234_5670; len_words = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #3;
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL zero_done_hi: got %b expected 1", done); end
    @(negedge clk);
    #3;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_lo: got %b expected 0", done); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (read_cyc != r0 || burst_addr_q.size() != b0) begin
      n_err++; $display("FAIL zero_no_read: read cycles %0d expected 0", read_cyc - r0);
    end
    n_cmp++;
    if (busy_cyc - bu0 > 1 || done_cnt - d0 != 1) begin
      n_err++; $display("FAIL zero_status: busy cycles %0d (max 1) done %0d expected 1",
                        busy_cyc - bu0, done_cnt - d0);
    end
  endtask

  task automatic test_waitrequest_stall();
    int w0 = wr_q.size();
    int d0 = done_cnt;
    int b0 = burst_addr_q.size();
    int s0 = stall_total;
    int sb0 = stab_bad;
    bit ok;
    stall_idx = b0 + 1;
    stall_len = 5;
    start_copy(32'h2000, 16'd16);
    wait_done(d0, 200, ok);
    repeat (3) @(negedge clk);
    stall_len = 0;
    stall_idx = -1;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_done: no done within 200 cycles"); end
    n_cmp++;
    if (stall_total - s0 != 5) begin
      n_err++; $display("FAIL stall_cycles: got %0d expected 5", stall_total - s0);
    end
    n_cmp++;
    if (stab_bad != sb0) begin
      n_err++; $display("FAIL stall_stable: %0d unstable cycles expected 0", stab_bad - sb0);
    end
    n_cmp++;
    if (burst_addr_q[b0 + 1] !== 32'h2020 || burst_cnt_q[b0 + 1] != 8) begin
      n_err++; $display("FAIL stall_burst: got %h/%0d expected 00002020/8",
                        burst_addr_q[b0 + 1], burst_cnt_q[b0 + 1]);
    end
    n_cmp++;
    if (wr_q.size() - w0 != 16 || stream_errors(w0, 32'h2000, 16) != 0) begin
      n_err++; $display("FAIL stall_data: %0d words %0d wrong expected 16 and 0",
                        wr_q.size() - w0, stream_errors(w0, 32'h2000, 16));
    end
  endtask

  task automatic test_almost_full();
    int w0 = wr_q.size();
    int d0 = done_cnt;
    int r0;
    bit ok;
    @(negedge clk);
    fifo_almost_full = 1'b1;
    start_copy(32'h3000, 16'd4);
    r0 = read_cyc;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (read_cyc != r0 || avm_read !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL af_hold: read cycles %0d read %b busy %b expected 0 0 1",
                        read_cyc - r0, avm_read, busy);
    end
    fifo_almost_full = 1'b0;
    #3;
    n_cmp++;
    if (avm_read !== 1'b1 || avm_address !== 32'h3000 || avm_burstcount !== 4'd4) begin
      n_err++; $display("FAIL af_release: read %b addr %h bc %0d expected 1 00003000 4",
                        avm_read, avm_address, avm_burstcount);
    end
    wait_done(d0, 100, ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || wr_q.size() - w0 != 4 || stream_errors(w0, 32'h3000, 4) != 0) begin
      n_err++; $display("FAIL af_data: done %b words %0d wrong %0d expected 1 4 0",
                        ok, wr_q.size() - w0, stream_errors(w0, 32'h3000, 4));
    end
  endtask

  task automatic test_addr_wrap();
    int w0 = wr_q.size();
    int d0 = done_cnt;
    int b0 = burst_addr_q.size();
    bit ok;
    start_copy(32'hFFFF_FFF0, 16'd10);
    wait_done(d0, 200, ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (burst_addr_q.size() - b0 != 2 || burst_addr_q[b0] !== 32'hFFFF_FFF0 || burst_cnt_q[b0] != 8
        || burst_addr_q[b0 + 1] !== 32'h0000_0010 || burst_cnt_q[b0 + 1] != 2) begin
      n_err++; $display("FAIL wrap_bursts: second burst %h/%0d expected 00000010/2",
                        burst_addr_q[b0 + 1], burst_cnt_q[b0 + 1]);
    end
    n_cmp++;
    if (!ok || wr_q.size() - w0 != 10 || stream_errors(w0, 32'hFFFF_FFF0, 10) != 0) begin
      n_err++; $display("FAIL wrap_data: done %b words %0d wrong %0d expected 1 10 0",
                        ok, wr_q.size() - w0, stream_errors(w0, 32'hFFFF_FFF0, 10));
    end
  endtask

  task automatic test_reset_mid_burst();
    int w0 = wr_q.size();
    int d0 = done_cnt;
    bit seen = 1'b0;
    start_copy(32'h4000, 16'd8);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (wr_q.size() - w0 >= 3) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rst_mid_reach: 3 beats not written within 50 cycles"); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({avm_read, busy, done, fifo_wrreq} !== 4'b0 || avm_address !== '0
        || avm_burstcount !== '0 || fifo_data !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: ctl %b addr %h bc %0d data %h expected all 0",
                        {avm_read, busy, done, fifo_wrreq}, avm_address, avm_burstcount, fifo_data);
    end
    @(negedge clk);
    #3;
    reset = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (wr_q.size() - w0 != 3 || stream_errors(w0, 32'h4000, 3) != 0) begin
      n_err++; $display("FAIL rst_mid_late: words %0d wrong %0d expected 3 0",
                        wr_q.size() - w0, stream_errors(w0, 32'h4000, 3));
    end
    n_cmp++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_idle: done %0d busy %b expected 0 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int w0 = wr_q.size();
    int d0 = done_cnt;
    int b0 = burst_addr_q.size();
    bit ok;
    start_copy(32'h5000, 16'd12);
    @(negedge clk);
    start = 1'b1; base_addr = 32'h9000; len_words = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0, 200, ok);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (!ok || done_cnt - d0 != 1) begin
      n_err++; $display("FAIL busy_done: done pulses %0d expected 1", done_cnt - d0);
    end
    n_cmp++;
    if (wr_q.size() - w0 != 12 || stream_errors(w0, 32'h5000, 12) != 0) begin
      n_err++; $display("FAIL busy_data: words %0d wrong %0d expected 12 0",
                        wr_q.size() - w0, stream_errors(w0, 32'h5000, 12));
    end
    n_cmp++;
    if (burst_addr_q.size() - b0 != 2 || burst_addr_q[b0 + 1] !== 32'h5020 || burst_cnt_q[b0 + 1] != 4) begin
      n_err++; $display("FAIL busy_bursts: count %0d second %h/%0d expected 2 00005020/4",
                        burst_addr_q.size() - b0, burst_addr_q[b0 + 1], burst_cnt_q[b0 + 1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    len_words = '0;
    fifo_almost_full = 1'b0;
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_waitrequest_stall();
    test_almost_full();
    test_addr_wrap();
    test_reset_mid_burst();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
